// File: rtl/sa_host_loader.sv
// Host-side sequencer for the systolic array: streams weights and input activations into
// the array memories, starts sa_control, waits for done, then drains the output memory.
module sa_host_loader #(
    parameter int HOST_WIDTH    = 32,
    parameter int INPUT_WIDTH   = 32,
    parameter int INPUT_HEIGHT  = 8,
    parameter int WEIGHT_WIDTH  = 32,
    parameter int WEIGHT_HEIGHT = 4,
    parameter int OUTPUT_WIDTH  = 32,
    parameter int OUTPUT_HEIGHT = 8,
    localparam int WA_W = (WEIGHT_HEIGHT > 1) ? $clog2(WEIGHT_HEIGHT) : 1,
    localparam int IA_W = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1,
    localparam int OA_W = (OUTPUT_HEIGHT > 1) ? $clog2(OUTPUT_HEIGHT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [HOST_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [HOST_WIDTH-1:0]   m_data,
    input  logic                    i_abort,
    output logic                    o_host_sel,
    output logic                    o_busy,
    output logic                    o_start,
    input  logic                    i_sa_done,
    output logic                    w_weight_cenb,
    output logic                    w_weight_wenb,
    output logic [WA_W-1:0]         w_weight_addr,
    output logic [WEIGHT_WIDTH-1:0] w_weight_data,
    output logic                    w_input_cenb,
    output logic                    w_input_wenb,
    output logic [IA_W-1:0]         w_input_addr,
    output logic [INPUT_WIDTH-1:0]  w_input_data,
    output logic                    r_output_cenb,
    output logic                    r_output_wenb,
    output logic [OA_W-1:0]         r_output_addr,
    input  logic [OUTPUT_WIDTH-1:0] i_output_data
);

    localparam int MAX_H = (WEIGHT_HEIGHT > INPUT_HEIGHT)
                         ? ((WEIGHT_HEIGHT > OUTPUT_HEIGHT) ? WEIGHT_HEIGHT : OUTPUT_HEIGHT)
                         : ((INPUT_HEIGHT > OUTPUT_HEIGHT) ? INPUT_HEIGHT : OUTPUT_HEIGHT);
    localparam int CNT_W = (MAX_H > 1) ? $clog2(MAX_H) : 1;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_W,
        LOAD_I,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RD_REQ,
        RD_WAIT,
        OUT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               beat;

    function automatic logic is_last(input logic [CNT_W-1:0] c, input int height);
        return c == CNT_W'(height - 1);
    endfunction

    function automatic logic [HOST_WIDTH-1:0] zext_out(input logic [OUTPUT_WIDTH-1:0] d);
        return HOST_WIDTH'(d);
    endfunction

    // A beat presented together with abort is never accepted.
    assign beat = s_valid & s_ready & ~i_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            s_ready       <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            o_start       <= 1'b0;
            o_host_sel    <= 1'b0;
            o_busy        <= 1'b0;
            w_weight_cenb <= 1'b1;
            w_weight_wenb <= 1'b1;
            w_weight_addr <= '0;
            w_weight_data <= '0;
            w_input_cenb  <= 1'b1;
            w_input_wenb  <= 1'b1;
            w_input_addr  <= '0;
            w_input_data  <= '0;
            r_output_cenb <= 1'b1;
            r_output_wenb <= 1'b1;
            r_output_addr <= '0;
        end else begin
            // Memory strobes and start are single-cycle; they fall back unless re-armed below.
            w_weight_cenb <= 1'b1;
            w_weight_wenb <= 1'b1;
            w_input_cenb  <= 1'b1;
            w_input_wenb  <= 1'b1;
            r_output_cenb <= 1'b1;
            r_output_wenb <= 1'b1;
            o_start       <= 1'b0;

            if (i_abort) begin
                state      <= IDLE;
                cnt        <= '0;
                s_ready    <= 1'b0;
                m_valid    <= 1'b0;
                o_host_sel <= 1'b0;
                o_busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (s_valid) begin
                            state      <= LOAD_W;
                            cnt        <= '0;
                            s_ready    <= 1'b1;
                            o_host_sel <= 1'b1;
                            o_busy     <= 1'b1;
                        end
                    end

                    LOAD_W: begin
                        if (beat) begin
                            w_weight_cenb <= 1'b0;
                            w_weight_wenb <= 1'b0;
                            w_weight_addr <= WA_W'(cnt);
                            w_weight_data <= s_data[WEIGHT_WIDTH-1:0];
                            if (is_last(cnt, WEIGHT_HEIGHT)) begin
                                state <= LOAD_I;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    LOAD_I: begin
                        if (beat) begin
                            w_input_cenb <= 1'b0;
                            w_input_wenb <= 1'b0;
                            w_input_addr <= IA_W'(cnt);
                            w_input_data <= s_data[INPUT_WIDTH-1:0];
                            if (is_last(cnt, INPUT_HEIGHT)) begin
                                state      <= START;
                                cnt        <= '0;
                                s_ready    <= 1'b0;
                                o_host_sel <= 1'b0;
                                o_start    <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    START: begin
                        state <= WAIT_BUSY;
                    end

                    // done is still high from sa_control idling; wait for it to drop first.
                    WAIT_BUSY: begin
                        if (!i_sa_done) begin
                            state <= WAIT_DONE;
                        end
                    end

                    WAIT_DONE: begin
                        if (i_sa_done) begin
                            state         <= RD_REQ;
                            cnt           <= '0;
                            o_host_sel    <= 1'b1;
                            r_output_cenb <= 1'b0;
                            r_output_addr <= '0;
                        end
                    end

                    RD_REQ: begin
                        state <= RD_WAIT;
                    end

                    RD_WAIT: begin
                        state   <= OUT;
                        m_data  <= zext_out(i_output_data);
                        m_valid <= 1'b1;
                    end

                    OUT: begin
                        if (m_ready) begin
                            m_valid <= 1'b0;
                            if (is_last(cnt, OUTPUT_HEIGHT)) begin
                                state      <= IDLE;
                                cnt        <= '0;
                                o_host_sel <= 1'b0;
                                o_busy     <= 1'b0;
                            end else begin
                                state         <= RD_REQ;
                                cnt           <= cnt + CNT_W'(1);
                                r_output_cenb <= 1'b0;
                                r_output_addr <= OA_W'(cnt + CNT_W'(1));
                            end
                        end
                    end

                    default: begin
                        state         <= IDLE;
                        cnt           <= 'x;
                        s_ready       <= 1'bx;
                        m_valid       <= 1'bx;
                        m_data        <= 'x;
                        o_start       <= 1'bx;
                        o_host_sel    <= 1'bx;
                        o_busy        <= 1'bx;
                        w_weight_cenb <= 1'bx;
                        w_weight_wenb <= 1'bx;
                        w_weight_addr <= 'x;
                        w_weight_data <= 'x;
                        w_input_cenb  <= 1'bx;
                        w_input_wenb  <= 1'bx;
                        w_input_addr  <= 'x;
                        w_input_data  <= 'x;
                        r_output_cenb <= 1'bx;
                        r_output_wenb <= 1'bx;
                        r_output_addr <= 'x;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sa_host_loader.sv
// Randomized bench for sa_host_loader with memory and sa_control models and a job-level scoreboard.
module tb_sa_host_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        i_abort = 1'b0;
    logic        o_host_sel;
    logic        o_busy;
    logic        o_start;
    logic        sa_done = 1'b1;
    logic        w_weight_cenb, w_weight_wenb;
    logic [1:0]  w_weight_addr;
    logic [31:0] w_weight_data;
    logic        w_input_cenb, w_input_wenb;
    logic [2:0]  w_input_addr;
    logic [31:0] w_input_data;
    logic        r_output_cenb, r_output_wenb;
    logic [2:0]  r_output_addr;
    logic [31:0] rdata = '0;

    sa_host_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .i_abort       (i_abort),
        .o_host_sel    (o_host_sel),
        .o_busy        (o_busy),
        .o_start       (o_start),
        .i_sa_done     (sa_done),
        .w_weight_cenb (w_weight_cenb),
        .w_weight_wenb (w_weight_wenb),
        .w_weight_addr (w_weight_addr),
        .w_weight_data (w_weight_data),
        .w_input_cenb  (w_input_cenb),
        .w_input_wenb  (w_input_wenb),
        .w_input_addr  (w_input_addr),
        .w_input_data  (w_input_data),
        .r_output_cenb (r_output_cenb),
        .r_output_wenb (r_output_wenb),
        .r_output_addr (r_output_addr),
        .i_output_data (rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Job scoreboard state
    logic [31:0] wtx [4];
    logic [31:0] itx [8];
    logic [31:0] omem [8];
    logic [31:0] rx [$];
    int  wr_w_n, wr_i_n, rd_n, start_n, n_beats, sel_err, early_err;
    bit  prev_beat, prev_stall, beat;
    logic [31:0] prev_data;
    int  busy_len = 3;
    int  busy_cnt = 0;
    bit  stall_mode = 1'b0;
    int  stall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output memory: registered read, data one cycle after the request edge.
    always @(posedge clk) begin
        if (!r_output_cenb && r_output_wenb) rdata <= omem[r_output_addr];
    end

    // sa_control stand-in: done drops after start and rises again busy_len cycles later.
    always @(posedge clk) begin
        if (o_start) begin
            busy_cnt <= busy_len;
            sa_done  <= 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) sa_done <= 1'b1;
        end
    end

    // Host result sink: optionally hold m_ready low for 5 cycles of every valid word.
    always @(posedge clk) begin
        #1;
        if (!stall_mode) begin
            m_ready = 1'b1;
        end else begin
            if (m_valid && !m_ready) stall_cnt++;
            else if (!m_valid) stall_cnt = 0;
            m_ready = (stall_cnt >= 5);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_beat  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            beat = s_valid && s_ready && !i_abort;
            if (beat) n_beats++;
            if (!w_weight_cenb) begin
                chk("w_after_beat", prev_beat, 1);
                chk("w_wenb", w_weight_wenb, 0);
                if (wr_w_n < 4) begin
                    chk("w_addr", w_weight_addr, wr_w_n);
                    chk("w_data", w_weight_data, wtx[wr_w_n]);
                end else chk("w_extra", wr_w_n, 3);
                wr_w_n++;
            end
            if (!w_input_cenb) begin
                chk("i_after_beat", prev_beat, 1);
                chk("i_after_w", wr_w_n, 4);
                chk("i_wenb", w_input_wenb, 0);
                if (wr_i_n < 8) begin
                    chk("i_addr", w_input_addr, wr_i_n);
                    chk("i_data", w_input_data, itx[wr_i_n]);
                end else chk("i_extra", wr_i_n, 7);
                wr_i_n++;
            end
            if (!r_output_cenb) begin
                chk("rd_wenb", r_output_wenb, 1);
                chk("rd_addr", r_output_addr, rd_n);
                if (!sa_done) early_err++;
                rd_n++;
            end
            if (!sa_done && o_host_sel) sel_err++;
            if (o_start) start_n++;
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) rx.push_back(m_data);
            prev_beat = beat;
        end
    end

    task automatic new_job();
        foreach (wtx[i]) wtx[i] = $urandom;
        foreach (itx[i]) itx[i] = $urandom;
        foreach (omem[i]) omem[i] = $urandom;
        rx.delete();
        wr_w_n = 0; wr_i_n = 0; rd_n = 0; start_n = 0;
        n_beats = 0; sel_err = 0; early_err = 0;
        prev_beat = 1'b0; prev_stall = 1'b0;
    endtask

    // Offer words until stop_at have been accepted; optionally keep valid high afterwards.
    task automatic send_words(input bit gap, input int stop_at, input int extra);
        int idx = 0;
        int cyc = 0;
        while (idx < stop_at && cyc < 500) begin
            @(posedge clk); #1;
            s_valid = gap ? (cyc % 2 == 0) : 1'b1;
            s_data  = (idx < 4) ? wtx[idx] : itx[idx - 4];
            @(negedge clk);
            if (s_valid && s_ready && !i_abort) idx++;
            cyc++;
        end
        if (cyc >= 500) chk("send_timeout", idx, stop_at);
        for (int k = 0; k < extra; k++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = $urandom;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while ((rx.size() < 8 || o_busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) chk("job_timeout", 0, 1);
    endtask

    task automatic check_job();
        chk("n_beats", n_beats, 12);
        chk("n_wwr", wr_w_n, 4);
        chk("n_iwr", wr_i_n, 8);
        chk("n_start", start_n, 1);
        chk("n_rd", rd_n, 8);
        chk("n_rx", rx.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx.size()) chk("rx_data", rx[i], omem[i]);
        end
        chk("sel_in_busy", sel_err, 0);
        chk("rd_before_done", early_err, 0);
        chk("end_busy", o_busy, 0);
        chk("end_sel", o_host_sel, 0);
        chk("end_mvalid", m_valid, 0);
    endtask

    task automatic run_job(input bit gap, input bit stall, input int blen, input int extra);
        stall_mode = stall;
        busy_len   = blen;
        new_job();
        send_words(gap, 12, extra);
        wait_done();
        check_job();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_o_start"}, o_start, 0);
        chk({tag, "_host_sel"}, o_host_sel, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_w_cenb"}, w_weight_cenb, 1);
        chk({tag, "_i_cenb"}, w_input_cenb, 1);
        chk({tag, "_r_cenb"}, r_output_cenb, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check_quiet("rst");
        chk("rst_m_data", m_data, 0);
        chk("rst_w_wenb", w_weight_wenb, 1);
        chk("rst_i_wenb", w_input_wenb, 1);
        chk("rst_r_wenb", r_output_wenb, 1);
        chk("rst_w_addr", w_weight_addr, 0);
        chk("rst_w_data", w_weight_data, 0);
        chk("rst_i_addr", w_input_addr, 0);
        chk("rst_r_addr", r_output_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Streaming job, extra valid beats offered while the array runs
        run_job(1'b0, 1'b0, $urandom_range(1, 6), 3);
        // Valid toggling every cycle
        run_job(1'b1, 1'b0, $urandom_range(1, 6), 0);
        // Host stalls each result word
        run_job(1'b0, 1'b1, $urandom_range(1, 6), 0);
        // Long busy window
        run_job(1'b0, 1'b0, 10, 0);

        // Abort while input word 3 is presented
        stall_mode = 1'b0;
        new_job();
        send_words(1'b0, 7, 0);
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = itx[3];
        i_abort = 1'b1;
        @(negedge clk);
        chk("abort_ready_before", s_ready, 1);
        @(posedge clk); #1;
        i_abort = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        chk("abort_iwr", wr_i_n, 3);
        chk("abort_beats", n_beats, 7);
        repeat (2) @(negedge clk);
        chk("abort_still_idle", o_busy, 0);
        run_job(1'b0, 1'b0, $urandom_range(1, 6), 0);

        // Async reset while a result word is pending
        stall_mode = 1'b1;
        busy_len   = 2;
        new_job();
        send_words(1'b0, 12, 0);
        cyc = 0;
        while (!m_valid && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_reached", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("arst");
        chk("arst_m_data", m_data, 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(1'b0, 1'b0, $urandom_range(1, 6), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
